// File: rtl/seg14_pkg.sv
// Character codes and 14-segment font shared by the display blocks.
// Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

    localparam int CHAR_W = 6;
    localparam int SEG_W  = 14;

    localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
    localparam logic [CHAR_W-1:0] CH_A     = 6'd1;
    localparam logic [CHAR_W-1:0] CH_E     = 6'd5;
    localparam logic [CHAR_W-1:0] CH_S     = 6'd19;
    localparam logic [CHAR_W-1:0] CH_X     = 6'd24;
    localparam logic [CHAR_W-1:0] CH_Z     = 6'd26;
    localparam logic [CHAR_W-1:0] CH_NTIL  = 6'd27;
    localparam logic [CHAR_W-1:0] CH_D0    = 6'd28;
    localparam logic [CHAR_W-1:0] CH_D2    = 6'd30;
    localparam logic [CHAR_W-1:0] CH_D9    = 6'd37;

    localparam logic [SEG_W-1:0] FONT_SPACE = 14'b00000000000000;
    localparam logic [SEG_W-1:0] FONT_A     = 14'b11101111000000;
    localparam logic [SEG_W-1:0] FONT_E     = 14'b10011110000000;
    localparam logic [SEG_W-1:0] FONT_S     = 14'b10110111000000;
    localparam logic [SEG_W-1:0] FONT_X     = 14'b00000000101101;
    localparam logic [SEG_W-1:0] FONT_NTIL  = 14'b10101011000000;
    localparam logic [SEG_W-1:0] FONT_D0    = 14'b11111100001001;
    localparam logic [SEG_W-1:0] FONT_D2    = 14'b11011011000000;

    // Indexed directly by character code 0..CH_D9.
    localparam logic [SEG_W-1:0] FONT_TAB [38] = '{
        FONT_SPACE,
        FONT_A,            14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
        FONT_E,            14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
        14'b10010000010010, 14'b01111000000000, 14'b00001110001100, 14'b00011100000000,
        14'b01101100101000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
        14'b11111100000100, 14'b11001111000100, FONT_S,            14'b10000000010010,
        14'b01111100000000, 14'b00001100001001, 14'b01101100000101, FONT_X,
        14'b00000000101010, 14'b10010000001001,
        FONT_NTIL,
        FONT_D0,           14'b01100000001000, FONT_D2,           14'b11110001000000,
        14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
        14'b11111111000000, 14'b11110111000000
    };

endpackage

// File: rtl/seg14_scroll_ctrl_if.sv
// Host-side write/config bus and scanned display outputs of the scroll sequencer.
interface seg14_scroll_ctrl_if #(
    parameter int DIGITS = 12,
    parameter int AW     = 6
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [5:0]        wr_char;
    logic [AW-1:0]     msg_len;
    logic              scroll_en;
    logic [DIGITS-1:0] sel;
    logic [13:0]       segm;
    logic              frame_tick;

    modport master (output wr_en, wr_addr, wr_char, msg_len, scroll_en,
                    input  sel, segm, frame_tick);
    modport slave  (input  wr_en, wr_addr, wr_char, msg_len, scroll_en,
                    output sel, segm, frame_tick);
endinterface

// File: rtl/seg14_font.sv
// Character code to 14-segment pattern; purely combinational, no backpressure.
// Codes beyond the last digit render as a blank.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  pattern
);
    always_comb begin
        pattern = FONT_SPACE;
        if (code <= CH_D9) pattern = FONT_TAB[code];
    end
endmodule

// File: rtl/seg14_scroll_ctrl.sv
// Message buffer scanned onto a multiplexed 14-seg display with optional left scroll.
// sel/segm registered together (one clock after the buffer read); free-running, no backpressure.
module seg14_scroll_ctrl
    import seg14_pkg::*;
#(
    parameter int DIGITS     = 12,
    parameter int MSG_LEN    = 32,
    parameter int SCAN_DIV   = 4,
    parameter int SCROLL_DIV = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seg14_scroll_ctrl_if.slave bus
);
    localparam int IW = $clog2(MSG_LEN);
    localparam int AW = IW + 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [CHAR_W-1:0] msg_buf [MSG_LEN];
    logic [DW-1:0]     digit;
    logic [HW-1:0]     hold;
    logic [IW-1:0]     offset, offset_nxt;
    logic [FW-1:0]     frame_cnt, frame_nxt;

    logic [AW-1:0]     len_eff;
    logic [AW:0]       rd_sum, rd_mod;
    logic [IW-1:0]     rd_idx;
    logic [CHAR_W-1:0] rd_char;
    logic [SEG_W-1:0]  rd_pat;
    logic              slot_end, frame_end, step;

    seg14_font u_font (
        .code    (rd_char),
        .pattern (rd_pat)
    );

    always_comb begin
        len_eff   = (bus.msg_len == '0 || bus.msg_len > AW'(MSG_LEN)) ? AW'(MSG_LEN) : bus.msg_len;
        // The modulo follows the live length, so a shrink mid-frame still reads in range.
        rd_sum    = (AW+1)'(offset) + (AW+1)'(digit);
        rd_mod    = rd_sum % {1'b0, len_eff};
        rd_idx    = IW'(rd_mod);
        rd_char   = msg_buf[rd_idx];
        slot_end  = (hold == HW'(SCAN_DIV - 1));
        frame_end = slot_end && (digit == DW'(DIGITS - 1));
        step      = bus.scroll_en && (frame_cnt == FW'(SCROLL_DIV - 1));

        offset_nxt = offset;
        frame_nxt  = frame_cnt;
        if (frame_end) begin
            if (bus.scroll_en) frame_nxt = step ? '0 : frame_cnt + 1'b1;
            if (AW'(offset) >= len_eff) offset_nxt = '0;
            else if (step) offset_nxt = (AW'(offset) + 1'b1 == len_eff) ? '0 : offset + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sel        <= '0;
            bus.segm       <= '0;
            bus.frame_tick <= 1'b0;
            digit          <= '0;
            hold           <= '0;
            offset         <= '0;
            frame_cnt      <= '0;
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= CH_SPACE;
        end else begin
            bus.sel        <= DIGITS'(1) << digit;
            bus.segm       <= rd_pat;
            bus.frame_tick <= frame_end;
            hold           <= slot_end ? '0 : hold + 1'b1;
            if (slot_end) digit <= (digit == DW'(DIGITS - 1)) ? '0 : digit + 1'b1;
            offset         <= offset_nxt;
            frame_cnt      <= frame_nxt;
            if (bus.wr_en && bus.wr_addr < AW'(MSG_LEN))
                msg_buf[IW'(bus.wr_addr)] <= bus.wr_char;
        end
    end
endmodule
